// File: rtl/game_pkg.sv
// Shared game definitions: round FSM state encoding and the data widths
// common to the round sequencer and the rating counter.
package game_pkg;

  localparam int RATING_WIDTH = 8;
  localparam int TARGET_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHOW   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_REPORT = 3'd3,
    ST_HOLD   = 3'd4
  } round_state_t;

endpackage

// File: rtl/round_sequencer_if.sv
// Player/target/rating-side signal bundle of the round sequencer.
// master drives the round inputs; slave is the sequencer itself.
interface round_sequencer_if #(
  parameter int RATING_WIDTH = game_pkg::RATING_WIDTH,
  parameter int TARGET_WIDTH = game_pkg::TARGET_WIDTH
);

  logic                    i_start;
  logic [TARGET_WIDTH-1:0] i_target;
  logic                    i_guess_valid;
  logic [TARGET_WIDTH-1:0] i_guess;
  logic [RATING_WIDTH-1:0] i_current_rating;
  logic [TARGET_WIDTH-1:0] o_target;
  logic                    o_show_target;
  logic                    o_window_open;
  logic                    o_round_ended;
  logic                    o_is_win;
  logic                    o_busy;

  modport master (
    output i_start, i_target, i_guess_valid, i_guess, i_current_rating,
    input  o_target, o_show_target, o_window_open, o_round_ended, o_is_win, o_busy
  );

  modport slave (
    input  i_start, i_target, i_guess_valid, i_guess, i_current_rating,
    output o_target, o_show_target, o_window_open, o_round_ended, o_is_win, o_busy
  );

endinterface

// File: rtl/round_timer.sv
// Loadable down-counter shared by the SHOW, WAIT and HOLD phases.
// A load of N makes expired rise on the Nth cycle after the load edge.
module round_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 expired
);

  logic [CNT_WIDTH-1:0] cnt_r;

  // Count register: load wins, otherwise count down and stop at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= load_value;
    end else if (cnt_r != {CNT_WIDTH{1'b0}}) begin
      cnt_r <= cnt_r - CNT_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Flags the last cycle of the loaded interval, so the FSM leaves on time
  assign expired = (cnt_r <= CNT_WIDTH'(1));

endmodule

// File: rtl/round_sequencer.sv
// Round controller: shows a latched target, opens a rating-dependent
// response window, judges the guess and pulses the verdict to the rating counter.
module round_sequencer
  import game_pkg::*;
#(
  parameter int RATING_WIDTH = game_pkg::RATING_WIDTH,
  parameter int TARGET_WIDTH = game_pkg::TARGET_WIDTH,
  parameter int CNT_WIDTH    = 16,
  parameter int SHOW_CYCLES  = 4,
  parameter int BASE_WINDOW  = 20,
  parameter int WINDOW_STEP  = 2,
  parameter int MIN_WINDOW   = 6,
  parameter int HOLD_CYCLES  = 3
) (
  input logic              clk,
  input logic              rst_n,
  round_sequencer_if.slave bus
);

  localparam int RED_WIDTH = RATING_WIDTH + 32;

  round_state_t            state_r;
  round_state_t            state_s;
  logic                    timer_load_s;
  logic [CNT_WIDTH-1:0]    timer_value_s;
  logic                    timer_expired_s;
  logic                    target_load_s;
  logic                    is_win_s;
  logic [RED_WIDTH-1:0]    red_s;
  logic [CNT_WIDTH-1:0]    window_s;
  logic [TARGET_WIDTH-1:0] target_r;
  logic                    is_win_r;
  logic                    show_r;
  logic                    open_r;
  logic                    ended_r;
  logic                    busy_r;

  round_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load_s),
    .load_value (timer_value_s),
    .expired    (timer_expired_s)
  );

  // Window length: full-width product so large ratings clamp instead of wrapping
  always_comb begin
    red_s = RED_WIDTH'(bus.i_current_rating) * RED_WIDTH'(WINDOW_STEP);
    if (red_s >= RED_WIDTH'(BASE_WINDOW - MIN_WINDOW)) begin
      window_s = CNT_WIDTH'(MIN_WINDOW);
    end else begin
      window_s = CNT_WIDTH'(BASE_WINDOW) - CNT_WIDTH'(red_s);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, timer control and verdict selection
  always_comb begin
    state_s       = state_r;
    timer_load_s  = 1'b0;
    timer_value_s = {CNT_WIDTH{1'b0}};
    target_load_s = 1'b0;
    is_win_s      = is_win_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_s       = ST_SHOW;
          timer_load_s  = 1'b1;
          timer_value_s = CNT_WIDTH'(SHOW_CYCLES);
          target_load_s = 1'b1;
          is_win_s      = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHOW: begin
        // Pressing before the window opens always loses
        if (bus.i_guess_valid) begin
          state_s  = ST_REPORT;
          is_win_s = 1'b0;
        end else if (timer_expired_s) begin
          state_s       = ST_WAIT;
          timer_load_s  = 1'b1;
          timer_value_s = window_s;
        end else begin
          state_s = ST_SHOW;
        end
      end
      ST_WAIT: begin
        if (bus.i_guess_valid) begin
          state_s  = ST_REPORT;
          is_win_s = (bus.i_guess == target_r);
        end else if (timer_expired_s) begin
          state_s  = ST_REPORT;
          is_win_s = 1'b0;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_REPORT: begin
        state_s       = ST_HOLD;
        timer_load_s  = 1'b1;
        timer_value_s = CNT_WIDTH'(HOLD_CYCLES);
      end
      ST_HOLD: begin
        if (timer_expired_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        is_win_s = 1'b0;
      end
    endcase
  end

  // Output registers, decoded from the next state so they align with state_r
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_r <= {TARGET_WIDTH{1'b0}};
      is_win_r <= 1'b0;
      show_r   <= 1'b0;
      open_r   <= 1'b0;
      ended_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      target_r <= target_load_s ? bus.i_target : target_r;
      is_win_r <= is_win_s;
      show_r   <= (state_s == ST_SHOW);
      open_r   <= (state_s == ST_WAIT);
      ended_r  <= (state_s == ST_REPORT);
      busy_r   <= (state_s != ST_IDLE);
    end
  end

  assign bus.o_target      = target_r;
  assign bus.o_is_win      = is_win_r;
  assign bus.o_show_target = show_r;
  assign bus.o_window_open = open_r;
  assign bus.o_round_ended = ended_r;
  assign bus.o_busy        = busy_r;

endmodule
